// File: rtl/nibble_adder_seq.sv
// Multi-cycle WIDTH-bit add/subtract built from one external 4-bit 74283 slice,
// processed one nibble per clock, LSB nibble first, with a registered ripple carry.
module nibble_adder_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout,
    output logic [1:0]       dbg_state
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              carry_r;
    logic [IW-1:0]     idx;
    logic              accept;
    logic              last;

    // Handshake: start is only honoured in IDLE or DONE; while RUN it is ignored.
    // done is a one-cycle pulse that qualifies result/cout/overflow/zero.
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));
    assign last   = (state == S_RUN) && (idx == IW'(NIB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Adder inputs come straight from registers so the slice sees a full cycle.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        dbg_state = state;
        case (state)
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_r[{idx, 2'b00} +: 4];
                add_b   = b_r[{idx, 2'b00} +: 4];
                add_cin = carry_r;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (accept) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry_r  <= sub;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (state == S_RUN) begin
            result[{idx, 2'b00} +: 4] <= add_sum;
            carry_r                   <= add_cout;
            if (last) begin
                cout     <= add_cout;
                overflow <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_sum[3] != a_r[WIDTH-1]);
                zero     <= (add_sum == 4'd0) && (result[WIDTH-5:0] == '0);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nibble_adder_seq.sv
// Self-checking bench for nibble_adder_seq with a behavioural 74283 slice and a
// whole-word arithmetic reference model.
module tb_nibble_adder_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
    logic         zero;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];

    nibble_adder_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .dbg_state (dbg_state)
    );

    // External 74283 slice
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-word reference model: plain arithmetic on the operands.
    function automatic void ref_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic ts, output logic [W-1:0] r,
                                   output logic c, output logic v, output logic z);
        longint sa, sb, sr;
        sa = longint'($signed(ta));
        sb = longint'($signed(tb_));
        if (ts) begin
            r  = ta - tb_;
            c  = (ta >= tb_);
            sr = sa - sb;
        end else begin
            r  = ta + tb_;
            c  = ({1'b0, ta} + {1'b0, tb_}) > {1'b0, {W{1'b1}}};
            sr = sa + sb;
        end
        v = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
        z = (r == '0);
    endfunction

    // Carry entering nibble k: whether the low 4k bits generate a carry (add) or no borrow (sub).
    function automatic logic ref_cin(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                     input logic ts, input int k);
        longint m, la, lb;
        m  = longint'(1) << (4 * k);
        la = longint'(ta) % m;
        lb = longint'(tb_) % m;
        return ts ? (la >= lb) : ((la + lb) >= m);
    endfunction

    // Driver tasks (called just after a rising edge)
    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_cmp++; if ({cout, overflow, zero} !== 3'b000)
            begin n_err++; $display("FAIL reset_flags got %b want 000", {cout, overflow, zero}); end
        n_cmp++; if ({add_a, add_b, add_cin} !== 9'd0)
            begin n_err++; $display("FAIL reset_adder got %h/%h/%b want 0", add_a, add_b, add_cin); end
    endtask

    task automatic test_directed();
        logic [W-1:0] d_a [6];
        logic [W-1:0] d_b [6];
        logic         d_s [6];
        logic [W-1:0] e_r [6];
        logic [2:0]   e_f [6];
        int cyc;
        d_a = '{16'h1234, 16'hFFFF, 16'h0005, 16'h0007, 16'h7FFF, 16'h8000};
        d_b = '{16'h0F0F, 16'h0001, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
        d_s = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        e_r = '{16'h2143, 16'h0000, 16'hFFFE, 16'h0002, 16'h8000, 16'h7FFF};
        // {cout, overflow, zero}
        e_f = '{3'b000, 3'b101, 3'b000, 3'b100, 3'b010, 3'b110};
        for (int i = 0; i < 6; i++) begin
            start_op(d_a[i], d_b[i], d_s[i]);
            cyc = 0;
            wait_done(cyc);
            n_cmp++; if (cyc !== NIB) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, cyc, NIB); end
            n_cmp++; if (result !== e_r[i]) begin n_err++; $display("FAIL dir%0d_result got %h want %h", i, result, e_r[i]); end
            n_cmp++; if ({cout, overflow, zero} !== e_f[i])
                begin n_err++; $display("FAIL dir%0d_flags got %b want %b", i, {cout, overflow, zero}, e_f[i]); end
            @(posedge clk); #1;
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL dir%0d_done_pulse got %b want 0", i, done); end
        end
    endtask

    task automatic test_carry_chain();
        start_op(16'hFFFF, 16'h0001, 1'b0);
        for (int k = 0; k < NIB; k++) begin
            n_cmp++; if (add_cin !== (k > 0))
                begin n_err++; $display("FAIL carry_cin%0d got %b want %b", k, add_cin, (k > 0)); end
            @(posedge clk); #1;
        end
        n_cmp++; if (done !== 1'b1 || result !== 16'h0000)
            begin n_err++; $display("FAIL carry_final got done=%b res=%h want done=1 res=0000", done, result); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tb_, er, got;
        logic ts, ec, ev, ez;
        logic [W-1:0] beff;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       ta = W'($urandom_range(0, 15)) | 16'h7FF0;
                1:       ta = W'($urandom_range(16'h8000, 16'hFFFF));
                default: ta = W'($urandom_range(0, 16'hFFFF));
            endcase
            tb_ = W'($urandom_range(0, 16'hFFFF));
            ts  = 1'($urandom_range(0, 1));
            ref_op(ta, tb_, ts, er, ec, ev, ez);
            exp_q.push_back(er);
            beff = ts ? ~tb_ : tb_;
            start_op(ta, tb_, ts);
            for (int k = 0; k < NIB; k++) begin
                n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
                    begin n_err++; $display("FAIL rnd%0d_busy%0d got busy=%b done=%b want 1/0", n, k, busy, done); end
                n_cmp++; if ({add_a, add_b, add_cin} !== {ta[4*k +: 4], beff[4*k +: 4], ref_cin(ta, tb_, ts, k)})
                    begin n_err++; $display("FAIL rnd%0d_adder%0d got %h/%h/%b want %h/%h/%b", n, k, add_a, add_b,
                        add_cin, ta[4*k +: 4], beff[4*k +: 4], ref_cin(ta, tb_, ts, k)); end
                @(posedge clk); #1;
            end
            n_cmp++; if (done !== 1'b1 || busy !== 1'b0)
                begin n_err++; $display("FAIL rnd%0d_done got done=%b busy=%b want 1/0", n, done, busy); end
            got = exp_q.pop_front();
            n_cmp++; if (result !== got) begin n_err++; $display("FAIL rnd%0d_result got %h want %h", n, result, got); end
            n_cmp++; if ({cout, overflow, zero} !== {ec, ev, ez})
                begin n_err++; $display("FAIL rnd%0d_flags got %b want %b", n, {cout, overflow, zero}, {ec, ev, ez}); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        int cyc;
        start_op(16'h1234, 16'h0F0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom_range(0, 16'hFFFF)); b = W'($urandom_range(0, 16'hFFFF));
            sub = 1'($urandom_range(0, 1)); start = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        cyc = 3;
        wait_done(cyc);
        n_cmp++; if (cyc !== NIB) begin n_err++; $display("FAIL ignore_latency got %0d want %0d", cyc, NIB); end
        n_cmp++; if (result !== 16'h2143) begin n_err++; $display("FAIL ignore_result got %h want 2143", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [W-1:0] er;
        logic ec, ev, ez;
        a = 16'h1234; b = 16'h0F0F; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'h0007; b = 16'h0005; sub = 1'b1;
        cyc = 0;
        wait_done(cyc);
        n_cmp++; if (cyc !== NIB) begin n_err++; $display("FAIL b2b_first_latency got %0d want %0d", cyc, NIB); end
        n_cmp++; if (result !== 16'h2143) begin n_err++; $display("FAIL b2b_first_result got %h want 2143", result); end
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        cyc = 1;
        wait_done(cyc);
        n_cmp++; if (cyc !== NIB + 1) begin n_err++; $display("FAIL b2b_period got %0d want %0d", cyc, NIB + 1); end
        ref_op(16'h0007, 16'h0005, 1'b1, er, ec, ev, ez);
        n_cmp++; if ({result, cout, overflow, zero} !== {er, ec, ev, ez})
            begin n_err++; $display("FAIL b2b_second got %h/%b want %h/%b", result, {cout, overflow, zero}, er, {ec, ev, ez}); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int cyc;
        logic seen_done;
        start_op(16'h1234, 16'h0F0F, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0)
            begin n_err++; $display("FAIL abort_ctrl got busy=%b done=%b want 0/0", busy, done); end
        n_cmp++; if (result !== '0) begin n_err++; $display("FAIL abort_result got %h want 0000", result); end
        n_cmp++; if ({add_a, add_b, add_cin} !== 9'd0)
            begin n_err++; $display("FAIL abort_adder got %h/%h/%b want 0", add_a, add_b, add_cin); end
        seen_done = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen_done |= done; end
        rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; seen_done |= done; end
        n_cmp++; if (seen_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done got %b want 0", seen_done); end
        start_op(16'h1234, 16'h0F0F, 1'b0);
        cyc = 0;
        wait_done(cyc);
        n_cmp++; if (cyc !== NIB || result !== 16'h2143)
            begin n_err++; $display("FAIL abort_recover got lat=%0d res=%h want %0d/2143", cyc, result, NIB); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_directed();
        test_carry_chain();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
